keypad_code_checker: RTL and testbench

- Consumes the 10-bit latched key vector from the keypad latch stage, one bit per digit 0-9.
- Each newly latched key is encoded to a digit and appended to an entry buffer. After each digit, the block pulses the latch stage's clear input so the next key can be latched.
- When CODE_LEN digits have been collected, the buffer is compared to a stored code and the block drives unlock or error.
- Includes an inactivity timeout and a lockout after repeated failures.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/key_encoder.sv | 30 +++
 rtl/keypad_code_checker.sv | 155 +++++++++++++++
 tb/tb_keypad_code_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad code checker.
// Key vector width, digit encoding and FSM state enum.
package keypad_pkg;

  localparam int KEY_W   = 10;
  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t DIGIT_INVALID = 4'hF;

  typedef enum logic [2:0] {
    COLLECT,
    CLEAR,
    CHECK,
    UNLOCK,
    FAIL,
    LOCKOUT
  } state_t;

endpackage

// File: rtl/key_encoder.sv
// Combinational encoder: newly pressed key bits to a digit.
// Ports: new_keys in; digit, valid (one-hot), multi (2+ bits) out.
module key_encoder
  import keypad_pkg::*;
(
  input  logic [KEY_W-1:0] new_keys,
  output digit_t           digit,
  output logic             valid,
  output logic             multi
);

  logic [3:0] ones;
  digit_t     idx;

  always_comb begin
    ones = '0;
    idx  = DIGIT_INVALID;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (new_keys[i]) begin
        idx  = DIGIT_W'(i);
        ones = ones + 4'd1;
      end
    end
  end

  assign valid = (ones == 4'd1);
  assign multi = (ones >= 4'd2);
  assign digit = valid ? idx : DIGIT_INVALID;

endmodule

// File: rtl/keypad_code_checker.sv
// Keypad entry FSM: collects digits, checks code, holds result.
// Ports: clk, reset (async low), keys in; latch_clear, unlock, error, locked_out, digit_count out.
module keypad_code_checker
  import keypad_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [CODE_LEN*4-1:0] CODE           = 16'h2580,
  parameter int                    HOLD_CYCLES    = 50,
  parameter int                    TIMEOUT_CYCLES = 1000,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 500
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [KEY_W-1:0]                  keys,
  output logic                              latch_clear,
  output logic                              unlock,
  output logic                              error,
  output logic                              locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

  localparam int BW   = CODE_LEN * DIGIT_W;
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TM1  = (HOLD_CYCLES > LOCKOUT_CYCLES) ?
                        HOLD_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = (TIMEOUT_CYCLES > TM1) ?
                        TIMEOUT_CYCLES : TM1;
  localparam int TW   = $clog2(TMAX + 1);

  state_t           state_q;
  logic [BW-1:0]    buf_q;
  logic [BW-1:0]    buf_d;
  logic [FW-1:0]    fail_q;
  logic [TW-1:0]    tmr_q;
  logic [KEY_W-1:0] keys_q;
  logic [KEY_W-1:0] new_keys;

  digit_t enc_digit;
  logic   enc_valid;
  logic   enc_multi;

  assign new_keys = keys & ~keys_q;

  // First digit ends up in the top nibble once the entry is full.
  assign buf_d = (buf_q << DIGIT_W) | BW'(enc_digit);

  key_encoder u_enc (
    .new_keys (new_keys),
    .digit    (enc_digit),
    .valid    (enc_valid),
    .multi    (enc_multi)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      buf_q       <= '0;
      digit_count <= '0;
      fail_q      <= '0;
      tmr_q       <= '0;
      keys_q      <= '0;
      latch_clear <= 1'b0;
      unlock      <= 1'b0;
      error       <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      keys_q <= keys;
      unique case (state_q)
        COLLECT: begin
          if (enc_valid || enc_multi) begin
            buf_q       <= buf_d;
            digit_count <= digit_count + 1'b1;
            tmr_q       <= '0;
            latch_clear <= 1'b1;
            state_q     <= CLEAR;
          end else if (digit_count != '0) begin
            if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
              buf_q       <= '0;
              digit_count <= '0;
              tmr_q       <= '0;
              latch_clear <= 1'b1;
              state_q     <= CLEAR;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
        end
        CLEAR: begin
          if (keys == '0) begin
            latch_clear <= 1'b0;
            if (digit_count == CW'(CODE_LEN))
              state_q <= CHECK;
            else
              state_q <= COLLECT;
          end
        end
        CHECK: begin
          buf_q       <= '0;
          digit_count <= '0;
          tmr_q       <= '0;
          if (buf_q == CODE) begin
            fail_q  <= '0;
            unlock  <= 1'b1;
            state_q <= UNLOCK;
          end else begin
            fail_q <= fail_q + 1'b1;
            error  <= 1'b1;
            if (fail_q == FW'(MAX_FAILS - 1)) begin
              locked_out <= 1'b1;
              state_q    <= LOCKOUT;
            end else begin
              state_q <= FAIL;
            end
          end
        end
        UNLOCK: begin
          if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
            tmr_q       <= '0;
            unlock      <= 1'b0;
            latch_clear <= 1'b1;
            state_q     <= CLEAR;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        FAIL: begin
          if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
            tmr_q       <= '0;
            error       <= 1'b0;
            latch_clear <= 1'b1;
            state_q     <= CLEAR;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        LOCKOUT: begin
          if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
            tmr_q       <= '0;
            fail_q      <= '0;
            error       <= 1'b0;
            locked_out  <= 1'b0;
            latch_clear <= 1'b1;
            state_q     <= CLEAR;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_checker.sv
// Self-checking bench for keypad_code_checker.
// Vector table, hand sequences and random entries vs a digit-level model.
module tb_keypad_code_checker;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int LOCK = 10;
  localparam int MAXF = 3;

  localparam int R_UNLOCK = 0;
  localparam int R_FAIL   = 1;
  localparam int R_LOCK   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] keys = '0;
  logic       latch_clear;
  logic       unlock;
  logic       error;
  logic       locked_out;
  logic [2:0] digit_count;

  int nchk = 0;
  int nfail = 0;
  int fails = 0;
  int code_d[4] = '{2, 5, 8, 0};

  always #5 clk = ~clk;

  keypad_code_checker #(
    .CODE_LEN       (4),
    .CODE           (16'h2580),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .MAX_FAILS      (MAXF),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys        (keys),
    .latch_clear (latch_clear),
    .unlock      (unlock),
    .error       (error),
    .locked_out  (locked_out),
    .digit_count (digit_count)
  );

  typedef struct {
    logic [3:0][9:0] k;
    int              res;
    string           nm;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [9:0] kb(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(input logic [9:0] v, input int cnt,
                       input string nm);
    bit seen;
    @(posedge clk); #1 keys = v;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (latch_clear) seen = 1;
    end
    check({nm, " clr_hi"}, 32'(seen), 1);
    check({nm, " count"}, 32'(digit_count), 32'(cnt));
    @(posedge clk); #1 keys = '0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!latch_clear) seen = 1;
    end
    check({nm, " clr_lo"}, 32'(seen), 1);
  endtask

  task automatic outcome(input int res, input string nm);
    bit seen;
    logic u, e, l;
    int len;
    int exp_len;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (unlock || error) seen = 1;
    end
    check({nm, " result"}, 32'(seen), 1);
    u = unlock;
    e = error;
    l = locked_out;
    check({nm, " count0"}, 32'(digit_count), 0);
    len = 0;
    while ((unlock || error) && len < 100) begin
      len++;
      @(negedge clk);
    end
    exp_len = (res == R_LOCK) ? LOCK : HOLD;
    check({nm, " unlock"}, 32'(u), 32'(res == R_UNLOCK));
    check({nm, " error"}, 32'(e), 32'(res != R_UNLOCK));
    check({nm, " locked"}, 32'(l), 32'(res == R_LOCK));
    check({nm, " length"}, 32'(len), 32'(exp_len));
    repeat (3) @(negedge clk);
  endtask

  task automatic entry(input logic [3:0][9:0] k, input int res,
                       input string nm);
    for (int i = 0; i < 4; i++)
      press(k[i], i + 1, nm);
    outcome(res, nm);
  endtask

  function automatic logic [3:0][9:0] good();
    logic [3:0][9:0] k;
    for (int i = 0; i < 4; i++) k[i] = kb(code_d[i]);
    return k;
  endfunction

  initial begin
    logic [3:0][9:0] k;
    bit bad;
    bit seen_lc;
    bit seen_err;
    int len;

    tbl[0].k = good();
    tbl[0].res = R_UNLOCK;
    tbl[0].nm = "correct";
    tbl[1].k = good();
    tbl[1].k[3] = kb(1);
    tbl[1].res = R_FAIL;
    tbl[1].nm = "wrong";
    tbl[2].k = good();
    tbl[2].k[0] = 10'h006;
    tbl[2].res = R_FAIL;
    tbl[2].nm = "multi";
    tbl[3].k = good();
    tbl[3].k[1] = kb(9);
    tbl[3].res = R_LOCK;
    tbl[3].nm = "third_fail";
    tbl[4].k = good();
    tbl[4].res = R_UNLOCK;
    tbl[4].nm = "after_lock";

    #12;
    check("rst latch_clear", 32'(latch_clear), 0);
    check("rst unlock", 32'(unlock), 0);
    check("rst error", 32'(error), 0);
    check("rst locked", 32'(locked_out), 0);
    check("rst count", 32'(digit_count), 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++)
      entry(tbl[i].k, tbl[i].res, tbl[i].nm);

    // keys pressed during lockout must be ignored
    k = good();
    k[2] = kb(7);
    entry(k, R_FAIL, "lk1");
    entry(k, R_FAIL, "lk2");
    for (int i = 0; i < 4; i++) press(k[i], i + 1, "lk3");
    seen_lc = 0;
    for (int i = 0; i < 10 && !seen_lc; i++) begin
      @(negedge clk);
      if (locked_out) seen_lc = 1;
    end
    check("lk3 locked", 32'(seen_lc), 1);
    check("lk3 error", 32'(error), 1);
    len = 0;
    bad = 0;
    while (locked_out && len < 100) begin
      len++;
      @(posedge clk);
      #1 keys = (len == 2 || len == 3) ? kb(3) : '0;
      @(negedge clk);
      if (locked_out && (latch_clear || digit_count != 0 || !error))
        bad = 1;
    end
    keys = '0;
    check("lk3 ignored", 32'(bad), 0);
    check("lk3 length", 32'(len), LOCK);
    repeat (3) @(negedge clk);
    entry(good(), R_UNLOCK, "post_lock");

    // timeout discards partial entry
    press(kb(2), 1, "tmo");
    press(kb(5), 2, "tmo");
    repeat (10) @(negedge clk);
    check("tmo mid count", 32'(digit_count), 2);
    seen_lc = 0;
    seen_err = 0;
    for (int i = 0; i < 30 && !seen_lc; i++) begin
      @(negedge clk);
      if (latch_clear) seen_lc = 1;
      if (error || unlock) seen_err = 1;
    end
    check("tmo latch_clear", 32'(seen_lc), 1);
    check("tmo count", 32'(digit_count), 0);
    check("tmo no_error", 32'(seen_err), 0);
    repeat (3) @(negedge clk);
    entry(good(), R_UNLOCK, "post_tmo");

    // async reset mid entry
    press(kb(2), 1, "arst");
    @(posedge clk); #1 keys = kb(5);
    repeat (2) @(negedge clk);
    check("arst pre clr", 32'(latch_clear), 1);
    #2 reset = 1'b0;
    #1;
    check("arst latch_clear", 32'(latch_clear), 0);
    check("arst count", 32'(digit_count), 0);
    check("arst outs", 32'({unlock, error, locked_out}), 0);
    keys = '0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    entry(good(), R_UNLOCK, "post_arst");

    // random entries against a digit-level model
    fails = 0;
    for (int n = 0; n < 40; n++) begin
      bit ok;
      int res;
      int mode;
      mode = $urandom_range(0, 2);
      ok = 1;
      for (int i = 0; i < 4; i++) begin
        logic [9:0] v;
        int d;
        if (mode == 0) d = code_d[i];
        else d = $urandom_range(0, 9);
        v = kb(d);
        if ($urandom_range(0, 7) == 0) begin
          do v = 10'($urandom_range(0, 1023));
          while ($countones(v) < 2);
        end
        k[i] = v;
        if ($countones(v) != 1 || d != code_d[i] || v != kb(d))
          ok = 0;
      end
      if (ok) begin
        fails = 0;
        res = R_UNLOCK;
      end else begin
        fails++;
        res = (fails == MAXF) ? R_LOCK : R_FAIL;
        if (fails == MAXF) fails = 0;
      end
      entry(k, res, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
